// File: rtl/user_spi_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : user_spi_arbiter_if
//  Description : Handshake bundle for the SPI frame arbiter. Carries both
//                requester byte streams, the byte handoff to the SPI shifter
//                and the chip-select / DC pins.
//                  req0_* / req1_* : valid, data[7:0], dc, last in; ready out
//                  shf_*           : valid, data[7:0] out; ready, done in
//                  spi_*           : cs1_no, cs2_no, dc_o out
//                  busy_o, grant_o : status out
//                master modport = arbiter view, slave modport = environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface user_spi_arbiter_if;
  logic       req0_valid_i;
  logic [7:0] req0_data_i;
  logic       req0_dc_i;
  logic       req0_last_i;
  logic       req0_ready_o;

  logic       req1_valid_i;
  logic [7:0] req1_data_i;
  logic       req1_dc_i;
  logic       req1_last_i;
  logic       req1_ready_o;

  logic       shf_valid_o;
  logic [7:0] shf_data_o;
  logic       shf_ready_i;
  logic       shf_done_i;

  logic       spi_cs1_no;
  logic       spi_cs2_no;
  logic       spi_dc_o;
  logic       busy_o;
  logic       grant_o;

  modport master (
    input  req0_valid_i, req0_data_i, req0_dc_i, req0_last_i,
    input  req1_valid_i, req1_data_i, req1_dc_i, req1_last_i,
    input  shf_ready_i, shf_done_i,
    output req0_ready_o, req1_ready_o,
    output shf_valid_o, shf_data_o,
    output spi_cs1_no, spi_cs2_no, spi_dc_o, busy_o, grant_o
  );

  modport slave (
    output req0_valid_i, req0_data_i, req0_dc_i, req0_last_i,
    output req1_valid_i, req1_data_i, req1_dc_i, req1_last_i,
    output shf_ready_i, shf_done_i,
    input  req0_ready_o, req1_ready_o,
    input  shf_valid_o, shf_data_o,
    input  spi_cs1_no, spi_cs2_no, spi_dc_o, busy_o, grant_o
  );
endinterface
`default_nettype wire

// File: rtl/user_spi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : user_spi_arbiter
//  Description : Frame-level arbiter/sequencer sharing one byte-wide SPI
//                shifter between two byte-stream requesters. Requester 0
//                owns CS1, requester 1 owns CS2. Round-robin grant on
//                contention, CS setup/hold/gap timing, DC line, burst split
//                after MaxBurst bytes when the other requester is waiting.
//  Ports       : clk_i  - clock
//                rst_i  - asynchronous reset, active-high
//                bus    - user_spi_arbiter_if.master (requesters, shifter,
//                         CS/DC pins, busy/grant status)
//  Revision    : 1.0 - initial release
// ============================================================================
module user_spi_arbiter #(
  parameter int CsSetupCycles = 2,
  parameter int CsHoldCycles  = 2,
  parameter int GapCycles     = 1,
  parameter int MaxBurst      = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  user_spi_arbiter_if.master bus
);

  localparam int BurstW   = $clog2(MaxBurst + 1);
  localparam int TimerMax = (CsSetupCycles > CsHoldCycles)
                          ? ((CsSetupCycles > GapCycles) ? CsSetupCycles : GapCycles)
                          : ((CsHoldCycles  > GapCycles) ? CsHoldCycles  : GapCycles);
  localparam int TimerW   = $clog2(TimerMax + 1);

  localparam logic [BurstW-1:0] BurstFull = BurstW'(MaxBurst);
  localparam logic [TimerW-1:0] SetupLast = TimerW'(CsSetupCycles - 1);
  localparam logic [TimerW-1:0] HoldLast  = TimerW'(CsHoldCycles - 1);
  localparam logic [TimerW-1:0] GapLast   = TimerW'(GapCycles - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    ACCEPT    = 3'd2,
    SEND      = 3'd3,
    WAIT_DONE = 3'd4,
    HOLD      = 3'd5,
    GAP       = 3'd6
  } state_t;

  state_t              state;
  logic [TimerW-1:0]   timer;
  logic [BurstW-1:0]   burst;
  logic                grant;
  logic                rr_ptr;     // requester favoured on a tie
  logic                cs1_n;
  logic                cs2_n;
  logic                dc;
  logic                shf_valid;
  logic [7:0]          shf_data;
  logic                ready0;
  logic                ready1;
  logic                busy;
  logic                last_latched;

  // Views of the granted / non-granted requester.
  logic       sel_valid;
  logic [7:0] sel_data;
  logic       sel_dc;
  logic       sel_last;
  logic       other_valid;
  logic       both_valid;
  logic       pick;

  assign sel_valid   = grant ? bus.req1_valid_i : bus.req0_valid_i;
  assign sel_data    = grant ? bus.req1_data_i  : bus.req0_data_i;
  assign sel_dc      = grant ? bus.req1_dc_i    : bus.req0_dc_i;
  assign sel_last    = grant ? bus.req1_last_i  : bus.req0_last_i;
  assign other_valid = grant ? bus.req0_valid_i : bus.req1_valid_i;
  assign both_valid  = bus.req0_valid_i & bus.req1_valid_i;
  // Tie goes to the pointer; otherwise whoever is asking (1 only if req1 alone).
  assign pick        = both_valid ? rr_ptr : bus.req1_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      timer        <= '0;
      burst        <= '0;
      grant        <= 1'b0;
      rr_ptr       <= 1'b0;
      cs1_n        <= 1'b1;
      cs2_n        <= 1'b1;
      dc           <= 1'b0;
      shf_valid    <= 1'b0;
      shf_data     <= 8'h00;
      ready0       <= 1'b0;
      ready1       <= 1'b0;
      busy         <= 1'b0;
      last_latched <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0_valid_i || bus.req1_valid_i) begin
            grant <= pick;
            cs1_n <= pick;
            cs2_n <= ~pick;
            busy  <= 1'b1;
            timer <= '0;
            state <= SETUP;
            if (both_valid) rr_ptr <= ~rr_ptr;
          end
        end

        SETUP: begin
          if (timer == SetupLast) begin
            timer  <= '0;
            ready0 <= ~grant;
            ready1 <= grant;
            state  <= ACCEPT;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ACCEPT: begin
          // Ready is already high for the granted side, so valid alone
          // completes the handshake.
          if (sel_valid) begin
            shf_data     <= sel_data;
            dc           <= sel_dc;
            last_latched <= sel_last;
            if (burst != BurstFull) burst <= burst + 1'b1;
            ready0       <= 1'b0;
            ready1       <= 1'b0;
            shf_valid    <= 1'b1;
            state        <= SEND;
          end
        end

        SEND: begin
          if (bus.shf_ready_i) begin
            shf_valid <= 1'b0;
            state     <= WAIT_DONE;
          end
        end

        WAIT_DONE: begin
          if (bus.shf_done_i) begin
            // Split the frame once the burst is used up and the other side
            // is waiting; the rest of this frame is re-arbitrated later.
            if (last_latched || ((burst == BurstFull) && other_valid)) begin
              timer <= '0;
              state <= HOLD;
            end else begin
              ready0 <= ~grant;
              ready1 <= grant;
              state  <= ACCEPT;
            end
          end
        end

        HOLD: begin
          if (timer == HoldLast) begin
            timer <= '0;
            cs1_n <= 1'b1;
            cs2_n <= 1'b1;
            burst <= '0;
            state <= GAP;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        GAP: begin
          if (timer == GapLast) begin
            timer <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          timer  <= '0;
          cs1_n  <= 1'b1;
          cs2_n  <= 1'b1;
          ready0 <= 1'b0;
          ready1 <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req0_ready_o = ready0;
  assign bus.req1_ready_o = ready1;
  assign bus.shf_valid_o  = shf_valid;
  assign bus.shf_data_o   = shf_data;
  assign bus.spi_cs1_no   = cs1_n;
  assign bus.spi_cs2_no   = cs2_n;
  assign bus.spi_dc_o     = dc;
  assign bus.busy_o       = busy;
  assign bus.grant_o      = grant;

endmodule
`default_nettype wire

// File: tb/tb_user_spi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_user_spi_arbiter
//  Description : Self-checking bench for user_spi_arbiter. Byte queues feed
//                both requesters, a shifter model returns done pulses, a
//                monitor records bytes/frames, and a transaction-level model
//                predicts the byte stream from the arbitration rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_user_spi_arbiter;

  localparam int SETUP = 2;
  localparam int HOLD  = 2;
  localparam int GAP   = 1;
  localparam int MAXB  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  user_spi_arbiter_if bus();

  user_spi_arbiter #(
    .CsSetupCycles(SETUP),
    .CsHoldCycles (HOLD),
    .GapCycles    (GAP),
    .MaxBurst     (MAXB)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       dc;
    logic       last;
  } byte_t;

  typedef struct {
    int         req;
    logic [7:0] data;
    logic       dc;
    bit         first;
  } xfer_t;

  typedef struct {
    int         req;
    logic [7:0] data;
    logic       dc;
    int         delay;
    int         exp_low;
    logic       exp_dc;
    logic       exp_grant;
  } vec_t;

  byte_t q0[$], q1[$], m0[$], m1[$];
  xfer_t obs[$], exp_q[$];
  int    fr_req[$], fr_len[$], gaps[$];

  int checks = 0;
  int errors = 0;
  int done_delay = 8;
  bit stall = 0;
  bit rand_stall = 0;
  int mptr = 0;

  // driver / monitor state
  bit         pend0 = 0, pend1 = 0, pend_s = 0, sh_busy = 0;
  bit         prev_sv = 0, prev_low = 0, low = 0;
  int         sh_cnt = 0, low_len = 0, high_len = 0, nbytes = 0;
  int         last_low_len = 0, sv_lat = 0;
  logic [7:0] rise_data = 8'h00;
  logic       rise_dc = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h @%0t", name, got, want, $time);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic dc, input logic last);
    byte_t b;
    b.data = d; b.dc = dc; b.last = last;
    if (r == 0) begin q0.push_back(b); m0.push_back(b); end
    else        begin q1.push_back(b); m1.push_back(b); end
  endtask

  // Transaction-level prediction: round-robin on ties, frames end at last,
  // or after MAXB bytes while the other requester still has bytes queued.
  task automatic run_model();
    while (m0.size() > 0 || m1.size() > 0) begin
      int    g;
      int    n;
      bit    fin;
      byte_t b;
      xfer_t e;
      if (m0.size() > 0 && m1.size() > 0) begin
        g = mptr;
        mptr = 1 - mptr;
      end else begin
        g = (m0.size() > 0) ? 0 : 1;
      end
      n = 0;
      fin = 0;
      while (!fin) begin
        b = (g == 1) ? m1.pop_front() : m0.pop_front();
        n++;
        e.req = g; e.data = b.data; e.dc = b.dc; e.first = (n == 1);
        exp_q.push_back(e);
        if (b.last) fin = 1;
        else if (n >= MAXB && ((g == 1) ? (m0.size() > 0) : (m1.size() > 0))) fin = 1;
        else if (((g == 1) ? m1.size() : m0.size()) == 0) fin = 1;
      end
    end
  endtask

  task automatic check_stream();
    xfer_t e, o;
    run_model();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_missing got=none want=req%0d data %0h", e.req, e.data);
      end else begin
        o = obs.pop_front();
        chk("stream_req", o.req, e.req);
        chk("stream_data", {24'h0, o.data}, {24'h0, e.data});
        chk("stream_dc", {31'h0, o.dc}, {31'h0, e.dc});
        chk("stream_first", {31'h0, o.first}, {31'h0, e.first});
      end
    end
    chk("stream_extra", obs.size(), 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    repeat (3) begin @(posedge clk); #2; end
    while (!(q0.size() == 0 && q1.size() == 0 && !bus.busy_o && !sh_busy) && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    chk("idle_within_budget", {31'h0, (n < budget)}, 32'h1);
  endtask

  task automatic clear_all();
    q0.delete(); q1.delete(); m0.delete(); m1.delete();
    obs.delete(); exp_q.delete();
    mptr = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    clear_all();
  endtask

  // Requester drivers, shifter model and monitor, all at the falling edge.
  initial begin : drv
    xfer_t x;
    bus.req0_valid_i = 0; bus.req0_data_i = 0; bus.req0_dc_i = 0; bus.req0_last_i = 0;
    bus.req1_valid_i = 0; bus.req1_data_i = 0; bus.req1_dc_i = 0; bus.req1_last_i = 0;
    bus.shf_ready_i = 1; bus.shf_done_i = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend0 = 0; pend1 = 0; pend_s = 0; sh_busy = 0;
        bus.shf_done_i = 0;
      end else begin
        if (pend0 && q0.size() > 0) void'(q0.pop_front());
        if (pend1 && q1.size() > 0) void'(q1.pop_front());
        bus.shf_done_i = 0;
        if (pend_s) begin sh_busy = 1; sh_cnt = 0; end
        if (sh_busy) begin
          sh_cnt++;
          if (sh_cnt >= done_delay) begin bus.shf_done_i = 1; sh_busy = 0; end
        end
      end
      bus.req0_valid_i = (q0.size() > 0);
      if (q0.size() > 0) begin
        bus.req0_data_i = q0[0].data; bus.req0_dc_i = q0[0].dc; bus.req0_last_i = q0[0].last;
      end
      bus.req1_valid_i = (q1.size() > 0);
      if (q1.size() > 0) begin
        bus.req1_data_i = q1[0].data; bus.req1_dc_i = q1[0].dc; bus.req1_last_i = q1[0].last;
      end
      bus.shf_ready_i = !(stall || (rand_stall && $urandom_range(0, 3) == 0));
      pend0  = bus.req0_valid_i && bus.req0_ready_o;
      pend1  = bus.req1_valid_i && bus.req1_ready_o;
      pend_s = bus.shf_valid_o && bus.shf_ready_i;

      // monitor
      low = !bus.spi_cs1_no || !bus.spi_cs2_no;
      chk("cs_not_both_low", {31'h0, (!bus.spi_cs1_no && !bus.spi_cs2_no)}, 32'h0);
      chk("ready_exclusive",
          {31'h0, ((bus.req0_ready_o && bus.req1_ready_o) ||
                   ((bus.req0_ready_o || bus.req1_ready_o) && bus.shf_valid_o))}, 32'h0);
      if (low && !prev_low) begin
        gaps.push_back(high_len);
        high_len = 0; low_len = 0; nbytes = 0;
        fr_req.push_back(bus.spi_cs1_no ? 1 : 0);
      end
      if (low) low_len++; else high_len++;
      if (!low && prev_low) begin
        fr_len.push_back(nbytes);
        last_low_len = low_len;
      end
      if (bus.shf_valid_o && !prev_sv) begin
        rise_data = bus.shf_data_o;
        rise_dc   = bus.spi_dc_o;
        if (nbytes == 0) sv_lat = low_len - 1;
      end else if (bus.shf_valid_o) begin
        chk("shf_stable", {23'h0, bus.shf_data_o, bus.spi_dc_o}, {23'h0, rise_data, rise_dc});
      end
      if (pend_s) begin
        x.req   = !bus.spi_cs1_no ? 0 : (!bus.spi_cs2_no ? 1 : -1);
        x.data  = rise_data;
        x.dc    = rise_dc;
        x.first = (nbytes == 0);
        obs.push_back(x);
        nbytes++;
      end
      prev_sv  = bus.shf_valid_o;
      prev_low = low;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : test
    vec_t vecs[5];
    int   base;
    int   exp_req[5];
    int   exp_len[5];

    vecs[0] = '{0, 8'hA5, 1'b1,  8, 14, 1'b1, 1'b0};
    vecs[1] = '{1, 8'h3C, 1'b0,  8, 14, 1'b0, 1'b1};
    vecs[2] = '{0, 8'hFF, 1'b0,  1,  7, 1'b0, 1'b0};
    vecs[3] = '{1, 8'h00, 1'b1,  3,  9, 1'b1, 1'b1};
    vecs[4] = '{0, 8'h5A, 1'b1, 20, 26, 1'b1, 1'b0};

    // reset state
    #12;
    chk("rst_cs1", {31'h0, bus.spi_cs1_no}, 32'h1);
    chk("rst_cs2", {31'h0, bus.spi_cs2_no}, 32'h1);
    chk("rst_dc", {31'h0, bus.spi_dc_o}, 32'h0);
    chk("rst_shf_valid", {31'h0, bus.shf_valid_o}, 32'h0);
    chk("rst_ready", {30'h0, bus.req1_ready_o, bus.req0_ready_o}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy_o}, 32'h0);
    chk("rst_grant", {31'h0, bus.grant_o}, 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;

    // single-byte frames from the table
    for (int i = 0; i < 5; i++) begin
      done_delay = vecs[i].delay;
      base = fr_req.size();
      push(vecs[i].req, vecs[i].data, vecs[i].dc, 1'b1);
      wait_idle(500);
      chk("vec_cs_low_cycles", last_low_len, vecs[i].exp_low);
      chk("vec_cs_to_valid", sv_lat, SETUP + 1);
      chk("vec_frame_count", fr_req.size() - base, 1);
      chk("vec_frame_req", fr_req[fr_req.size() - 1], vecs[i].req);
      chk("vec_grant", {31'h0, bus.grant_o}, {31'h0, vecs[i].exp_grant});
      chk("vec_dc_held", {31'h0, bus.spi_dc_o}, {31'h0, vecs[i].exp_dc});
      check_stream();
    end

    // contention: both valid together from a fresh reset
    do_reset();
    done_delay = 4;
    base = fr_req.size();
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 3; b++) push(0, 8'(8'h10 + 8 * f + b), 1'b1, b == 2);
      for (int b = 0; b < 3; b++) push(1, 8'(8'h80 + 8 * f + b), 1'b0, b == 2);
    end
    wait_idle(1000);
    chk("cont_frames", fr_req.size() - base, 4);
    if (fr_req.size() - base >= 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("cont_order", fr_req[base + k], k % 2);
        chk("cont_len", fr_len[base + k], 3);
        if (k > 0) chk("cont_gap", gaps[base + k], GAP + 1);
      end
    end
    check_stream();

    // DC switching inside one CS2 frame
    done_delay = 3;
    base = fr_req.size();
    push(1, 8'h2A, 1'b0, 1'b0);
    push(1, 8'h00, 1'b1, 1'b0);
    push(1, 8'h7F, 1'b1, 1'b1);
    wait_idle(500);
    chk("dc_frames", fr_req.size() - base, 1);
    if (fr_req.size() - base >= 1) begin
      chk("dc_frame_req", fr_req[base], 1);
      chk("dc_frame_len", fr_len[base], 3);
    end
    check_stream();

    // burst split at MAXB while the other requester waits
    do_reset();
    done_delay = 2;
    base = fr_req.size();
    for (int b = 1; b <= 10; b++) push(0, 8'(b), 1'b1, b == 10);
    push(1, 8'hB1, 1'b0, 1'b0);
    push(1, 8'hB2, 1'b1, 1'b1);
    push(1, 8'hC1, 1'b0, 1'b0);
    push(1, 8'hC2, 1'b1, 1'b1);
    exp_req = '{0, 1, 0, 1, 0};
    exp_len = '{4, 2, 4, 2, 2};
    wait_idle(2000);
    chk("burst_frames", fr_req.size() - base, 5);
    if (fr_req.size() - base >= 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("burst_order", fr_req[base + k], exp_req[k]);
        chk("burst_len", fr_len[base + k], exp_len[k]);
      end
    end
    check_stream();

    // shifter stall: byte held, no further accept
    done_delay = 2;
    stall = 1;
    push(0, 8'hC3, 1'b1, 1'b0);
    push(0, 8'h3C, 1'b1, 1'b1);
    begin
      int n = 0;
      while (!bus.shf_valid_o && n < 50) begin @(posedge clk); #2; n++; end
      chk("stall_valid_seen", {31'h0, (n < 50)}, 32'h1);
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #2;
      chk("stall_valid", {31'h0, bus.shf_valid_o}, 32'h1);
      chk("stall_data", {24'h0, bus.shf_data_o}, 32'hC3);
      chk("stall_ready0", {31'h0, bus.req0_ready_o}, 32'h0);
    end
    stall = 0;
    wait_idle(500);
    check_stream();

    // asynchronous reset during WAIT_DONE
    done_delay = 30;
    push(0, 8'h99, 1'b1, 1'b1);
    begin
      int n = 0;
      while (!sh_busy && n < 50) begin @(posedge clk); #2; n++; end
      chk("rstmid_shifting", {31'h0, sh_busy}, 32'h1);
    end
    repeat (3) @(posedge clk);
    #2;
    chk("rstmid_cs1_before", {31'h0, bus.spi_cs1_no}, 32'h0);
    rst = 1'b1;
    #1;
    chk("rstmid_cs1", {31'h0, bus.spi_cs1_no}, 32'h1);
    chk("rstmid_cs2", {31'h0, bus.spi_cs2_no}, 32'h1);
    chk("rstmid_shf_valid", {31'h0, bus.shf_valid_o}, 32'h0);
    chk("rstmid_ready", {30'h0, bus.req1_ready_o, bus.req0_ready_o}, 32'h0);
    chk("rstmid_busy", {31'h0, bus.busy_o}, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    clear_all();
    chk("rstmid_idle", {31'h0, bus.busy_o}, 32'h0);
    done_delay = 2;
    base = fr_req.size();
    push(1, 8'h11, 1'b1, 1'b1);
    push(0, 8'h22, 1'b0, 1'b1);
    wait_idle(500);
    chk("rstmid_frames", fr_req.size() - base, 2);
    if (fr_req.size() - base >= 2) begin
      chk("rstmid_first_req0", fr_req[base], 0);
      chk("rstmid_then_req1", fr_req[base + 1], 1);
    end
    check_stream();

    // randomized traffic against the transaction model
    rand_stall = 1;
    for (int r = 0; r < 8; r++) begin
      int nf0, nf1, len;
      done_delay = $urandom_range(1, 10);
      nf0 = $urandom_range(0, 3);
      nf1 = $urandom_range(0, 3);
      if (nf0 + nf1 == 0) nf0 = 1;
      for (int f = 0; f < nf0; f++) begin
        len = $urandom_range(1, 7);
        for (int b = 0; b < len; b++) push(0, 8'($urandom), 1'($urandom), b == len - 1);
      end
      for (int f = 0; f < nf1; f++) begin
        len = $urandom_range(1, 7);
        for (int b = 0; b < len; b++) push(1, 8'($urandom), 1'($urandom), b == len - 1);
      end
      wait_idle(5000);
      check_stream();
    end
    rand_stall = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
